aes_dec_round_ctrl: RTL and testbench
=====================================

Name: aes_dec_round_ctrl

Overview:
- Iterative AES-128 decryption sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake.
- Fetches round keys 10 down to 0 from an external synchronous key store. Applies the initial AddRoundKey (XOR) itself.
- Drives an external combinational inverse-round datapath once per round; returns plaintext over a valid/ready handshake.
- Sits between the decrypt input interface and the inverse-round / key-memory blocks of the Decrypt path.

Parameters:
- NR, 10, number of rounds; round keys indexed 0..NR.
- KEY_ADDR_W, 4, key-store address width; must satisfy 2^KEY_ADDR_W > NR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext available.
- in_ready  out  1  controller idle; ciphertext accepted on in_valid&&in_ready.
- in_data  in  128  ciphertext block.
- key_addr  out  KEY_ADDR_W  round-key index presented to key store.
- key_data  in  128  round key; valid one cycle after key_addr is presented (registered read).
- rnd_state  out  128  current state register, to inverse-round datapath.
- rnd_key  out  128  equals key_data, to inverse-round datapath.
- rnd_last  out  1  high during the final round: datapath skips InvMixColumns.
- rnd_result  in  128  combinational inverse-round result for rnd_state/rnd_key/rnd_last.
- out_valid  out  1  plaintext available.
- out_ready  in  1  downstream accepts; transfer on out_valid&&out_ready.
- out_data  out  128  plaintext block; equals state register.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: fsm=IDLE, state=0, key_addr=NR, rnd_cnt=0, out_valid=0, busy=0, in_ready=1 (after reset).
- FSM states:
  - IDLE: in_ready=1. On handshake, capture in_data into the ciphertext register, key_addr<=NR, go to KEY.
  - KEY: key store registers rk[NR]. key_addr<=NR-1, go to ARK.
  - ARK: state<=cipher^key_data (XOR). key_addr<=NR-2, rnd_cnt<=NR-1, go to ROUND.
  - ROUND: state<=rnd_result with rnd_last=0. rnd_cnt<=rnd_cnt-1. key_addr<=key_addr-1, saturating at 0. Go to FINAL when rnd_cnt==1.
  - FINAL: rnd_last=1; state<=rnd_result; go to DONE.
  - DONE: out_valid=1; hold state until out_ready, then go to IDLE.
- Latency and throughput:
  - Accept edge E0. ARK at E2. Rounds NR-1..1 at E3..E(NR+1). FINAL at E(NR+2).
  - out_valid is first high after E(NR+2): 12 cycles for NR=10.
  - One round per cycle after prefetch.
- Key-address arithmetic is unsigned KEY_ADDR_W bits. key_addr never wraps below 0.
- in_ready=0 in every non-IDLE state, including DONE; there is no same-cycle output/input overlap. The next accept is at earliest the cycle after the output handshake.
- out_valid stays high and out_data stays stable while out_ready=0 (backpressure indefinitely).
- in_valid is ignored while busy; in_data may change freely then.
- rst mid-operation: abort next edge to reset values; partial result discarded; no out_valid.
- rst has priority over all handshakes in the same cycle.

Optional Feature:
- Macro: AES_DEC_ZEROIZE_EN.
- With AES_DEC_ZEROIZE_EN: on the output handshake, state and the ciphertext register clear to 0. out_data is forced to 0 whenever out_valid=0.
- Without AES_DEC_ZEROIZE_EN: registers hold their last values. out_data shows the state register in all states.

Decomposition:
- Package aes_dec_pkg: state enum (IDLE, KEY, ARK, ROUND, FINAL, DONE), AES_BLOCK_W=128, AES128_NR=10.
- Sub-module: none natural. The XOR step is inline; the inverse round lives outside this block.

Test Plan:
- FIPS-197 C.1 vector (ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102…0f), model key store plus golden inverse round -> out_data=00112233445566778899aabbccddeeff, out_valid exactly 12 cycles after accept.
- Key-address trace -> key_addr sequence 10,9,8,…,0 on consecutive cycles starting at the accept edge; rnd_last high only in FINAL.
- Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
- Pulse rst at cycle 5 of a decryption -> next cycle busy=0, out_valid=0, state=0; new block then decrypts correctly.
- Toggle in_valid with random data while busy -> result unaffected, no extra accept.
- AES_DEC_ZEROIZE_EN: after the output handshake -> out_data=0; without the macro -> out_data still equals the plaintext.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// ---------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the AES-128 decrypt sequencer:
//   AES_BLOCK_W  - block and round-key width in bits
//   AES128_NR    - AES-128 round count
//   dec_state_e  - sequencer FSM states
// ---------------------------------------------------------------------------
package aes_dec_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        ARK,
        ROUND,
        FINAL,
        DONE
    } dec_state_e;

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_dec_round_ctrl
// Iterative AES-128 decryption sequencer. Takes one ciphertext block,
// fetches round keys NR..0 from a registered-read key store, performs the
// initial AddRoundKey itself and steps an external combinational
// inverse-round datapath once per cycle, then presents the plaintext.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/ready    ciphertext handshake; in_data is the ciphertext block
//   key_addr          round-key index to the key store
//   key_data          round key, valid one cycle after key_addr
//   rnd_state/key     operands to the inverse-round datapath
//   rnd_last          final round (datapath skips InvMixColumns)
//   rnd_result        inverse-round result
//   out_valid/ready   plaintext handshake; out_data is the plaintext block
//   busy              sequencer is not idle
//
// Build option:
//   AES_DEC_ZEROIZE_EN - clear state/ciphertext on the output handshake and
//                        force out_data to 0 while out_valid is low.
// ---------------------------------------------------------------------------
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR         = AES128_NR,
    parameter int KEY_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic [KEY_ADDR_W-1:0]  key_addr,
    input  logic [AES_BLOCK_W-1:0] key_data,
    output logic [AES_BLOCK_W-1:0] rnd_state,
    output logic [AES_BLOCK_W-1:0] rnd_key,
    output logic                   rnd_last,
    input  logic [AES_BLOCK_W-1:0] rnd_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int CNT_W = $clog2(NR + 1);
    localparam logic [KEY_ADDR_W-1:0] ADDR_NR = KEY_ADDR_W'(NR);

    dec_state_e               r_fsm;
    logic [AES_BLOCK_W-1:0]   r_state;
    logic [AES_BLOCK_W-1:0]   r_cipher;
    logic [KEY_ADDR_W-1:0]    r_key_addr;
    logic [CNT_W-1:0]         r_rnd_cnt;

    dec_state_e               w_fsm_nxt;
    logic [AES_BLOCK_W-1:0]   w_state_nxt;
    logic [AES_BLOCK_W-1:0]   w_cipher_nxt;
    logic [KEY_ADDR_W-1:0]    w_key_addr_nxt;
    logic [CNT_W-1:0]         w_rnd_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_state    <= '0;
            r_cipher   <= '0;
            r_key_addr <= ADDR_NR;
            r_rnd_cnt  <= '0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_state    <= w_state_nxt;
            r_cipher   <= w_cipher_nxt;
            r_key_addr <= w_key_addr_nxt;
            r_rnd_cnt  <= w_rnd_cnt_nxt;
        end
    end

    // The key address always runs one step ahead of the state update to
    // cover the key store's registered read.
    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_state_nxt    = r_state;
        w_cipher_nxt   = r_cipher;
        w_key_addr_nxt = r_key_addr;
        w_rnd_cnt_nxt  = r_rnd_cnt;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        rnd_last       = 1'b0;

        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_cipher_nxt   = in_data;
                    w_key_addr_nxt = ADDR_NR;
                    w_fsm_nxt      = KEY;
                end
            end
            KEY: begin
                w_key_addr_nxt = ADDR_NR - KEY_ADDR_W'(1);
                w_fsm_nxt      = ARK;
            end
            ARK: begin
                w_state_nxt    = r_cipher ^ key_data;
                w_key_addr_nxt = ADDR_NR - KEY_ADDR_W'(2);
                w_rnd_cnt_nxt  = CNT_W'(NR - 1);
                w_fsm_nxt      = ROUND;
            end
            ROUND: begin
                w_state_nxt    = rnd_result;
                w_rnd_cnt_nxt  = r_rnd_cnt - CNT_W'(1);
                w_key_addr_nxt = (r_key_addr == '0) ? '0
                                                    : r_key_addr - KEY_ADDR_W'(1);
                if (r_rnd_cnt == CNT_W'(1)) begin
                    w_fsm_nxt = FINAL;
                end
            end
            FINAL: begin
                rnd_last    = 1'b1;
                w_state_nxt = rnd_result;
                w_fsm_nxt   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_nxt = IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                    w_state_nxt  = '0;
                    w_cipher_nxt = '0;
`endif
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    assign key_addr  = r_key_addr;
    assign rnd_state = r_state;
    assign rnd_key   = key_data;
    assign busy      = (r_fsm != IDLE);

`ifdef AES_DEC_ZEROIZE_EN
    assign out_data = (r_fsm == DONE) ? r_state : '0;
`else
    assign out_data = r_state;
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_round_ctrl
// Directed bench for aes_dec_round_ctrl. Provides a registered key store
// loaded from an AES-128 key expansion and a reference inverse-round
// datapath, then checks published AES plaintexts, timing, key addressing,
// backpressure, mid-operation reset and input isolation while busy.
// Honours AES_DEC_ZEROIZE_EN for the post-handshake out_data expectation.
// ---------------------------------------------------------------------------
module tb_aes_dec_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic         rnd_last;
    logic [127:0] rnd_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk_mem [16];

    aes_dec_round_ctrl #(.NR(10), .KEY_ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_addr   (key_addr),
        .key_data   (key_data),
        .rnd_state  (rnd_state),
        .rnd_key    (rnd_key),
        .rnd_last   (rnd_last),
        .rnd_result (rnd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- GF(2^8) helpers and reference tables ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
    // then InvMixColumns unless this is the last round.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] r;
        logic [7:0]   c0, c1, c2, c3;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[c*4+rw] = isbox[a[((c - rw + 4) % 4)*4 + rw]];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        r = r ^ k;
        if (!last) begin
            for (int i = 0; i < 16; i++) a[i] = r[127-8*i -: 8];
            for (int c = 0; c < 4; c++) begin
                c0 = a[4*c]; c1 = a[4*c+1]; c2 = a[4*c+2]; c3 = a[4*c+3];
                t[4*c]   = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
                t[4*c+1] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
                t[4*c+2] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
                t[4*c+3] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
            end
            for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        end
        return r;
    endfunction

    // Registered-read key store.
    always @(posedge clk) key_data <= rk_mem[key_addr];

    // Datapath operands only change on rising edges, so a falling-edge
    // evaluation is settled by the next rising edge.
    always @(negedge clk) rnd_result = inv_round(rnd_state, rnd_key, rnd_last);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        build_tables();
        load_key(KEY_C1);

        // ---- reset state ----
        repeat (2) tick();
        chk("rst_busy",      busy,      1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_key_addr",  key_addr,  4'd10);
        chk("rst_rnd_last",  rnd_last,  1'b0);
        chk("rst_out_data",  out_data,  '0);
        rst = 1'b0;
        tick();

        // ---- FIPS-197 C.1: timing, key-address trace, rnd_last ----
        in_valid = 1'b1;
        in_data  = CT_C1;
        tick();                     // accept edge E0
        in_valid = 1'b0;
        in_data  = '0;
        chk("c1_accept_busy",     busy,     1'b1);
        chk("c1_accept_in_ready", in_ready, 1'b0);
        chk("c1_keyaddr_e0",      key_addr, 4'd10);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("c1_keyaddr_e%0d", k),  key_addr,  (k <= 10) ? 4'(10 - k) : 4'd0);
            chk($sformatf("c1_rnd_last_e%0d", k), rnd_last,  (k == 11) ? 1'b1 : 1'b0);
            chk($sformatf("c1_out_valid_e%0d", k), out_valid, 1'b0);
        end
        tick();                     // E12
        chk("c1_out_valid_e12", out_valid, 1'b1);
        chk("c1_out_data",      out_data,  PT_C1);
        chk("c1_rnd_last_done", rnd_last,  1'b0);

        // ---- backpressure, with ignored input traffic ----
        in_valid = 1'b1;
        in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hold_out_data_%0d", k),  out_data,  PT_C1);
            chk($sformatf("hold_out_valid_%0d", k), out_valid, 1'b1);
            chk($sformatf("hold_in_ready_%0d", k),  in_ready,  1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();                     // output handshake
        out_ready = 1'b0;
        chk("rel_busy",      busy,      1'b0);
        chk("rel_in_ready",  in_ready,  1'b1);
        chk("rel_out_valid", out_valid, 1'b0);
`ifdef AES_DEC_ZEROIZE_EN
        chk("rel_out_data_zeroized", out_data, '0);
`else
        chk("rel_out_data_held",     out_data, PT_C1);
`endif
        tick();

        // ---- reset mid-operation ----
        in_valid = 1'b1;
        in_data  = CT_C1;
        tick();                     // accept
        in_valid = 1'b0;
        repeat (5) tick();
        chk("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",      busy,      1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_state",     rnd_state, '0);
        chk("midrst_key_addr",  key_addr,  4'd10);
        chk("midrst_in_ready",  in_ready,  1'b1);
        repeat (14) tick();
        chk("midrst_no_output", out_valid, 1'b0);
        chk("midrst_idle",      busy,      1'b0);

        // ---- FIPS-197 Appendix B block with input noise while busy ----
        load_key(KEY_B);
        in_valid = 1'b1;
        in_data  = CT_B;
        tick();                     // accept edge E0
        for (int k = 1; k <= 12; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            chk($sformatf("noise_busy_e%0d", k), busy, 1'b1);
            chk($sformatf("noise_out_valid_e%0d", k), out_valid, (k == 12) ? 1'b1 : 1'b0);
        end
        chk("b_out_data", out_data, PT_B);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b_rel_busy",     busy,     1'b0);
        chk("b_rel_in_ready", in_ready, 1'b1);
        repeat (3) tick();
        chk("b_no_extra_accept", busy,      1'b0);
        chk("b_no_extra_output", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
